// File: rtl/sramlike_pkg.sv
// -----------------------------------------------------------------------------
// sramlike_pkg
// Shared definitions for the sram-like data bus. Both the data responder and
// the CPU store path use these.
//   SIZE_BYTE / SIZE_HALF / SIZE_WORD : encodings of the 2-bit size field
//                                       (3 is handled like SIZE_WORD)
//   byte_en(size, addr_lo)            : 4-bit lane enable for a store
// -----------------------------------------------------------------------------
package sramlike_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // The master has already placed the data on the right lanes. The enable
    // only selects which lanes get written. Misaligned offsets are not
    // checked here: a half ignores addr[0] and a word ignores addr[1:0].
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/sramlike_delay_line.sv
// -----------------------------------------------------------------------------
// sramlike_delay_line
// A shift register of LATENCY stages that carries a valid bit and a data word.
// The asynchronous active-low clear drops everything in flight.
//   clk        : rising-edge clock
//   rst        : asynchronous clear, active low
//   load_valid : valid bit entering stage 0
//   load_data  : data entering stage 0 (W bits)
//   tap_valid  : valid bit leaving the last stage
//   tap_data   : data leaving the last stage (W bits)
// -----------------------------------------------------------------------------
module sramlike_delay_line #(
    parameter int W       = 32,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    output logic         tap_valid,
    output logic [W-1:0] tap_data
);

    logic [LATENCY-1:0] valid_reg;
    logic [W-1:0]       data_reg [LATENCY];

    // The data word shifts on every cycle, valid or not. The producer keeps
    // the data at zero whenever valid is low. So the tap only shows a
    // non-zero word together with tap_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                data_reg[s] <= '0;
            end
        end else begin
            valid_reg[0] <= load_valid;
            data_reg[0]  <= load_data;
            for (int s = 1; s < LATENCY; s++) begin
                valid_reg[s] <= valid_reg[s-1];
                data_reg[s]  <= data_reg[s-1];
            end
        end
    end

    assign tap_valid = valid_reg[LATENCY-1];
    assign tap_data  = data_reg[LATENCY-1];

endmodule

// File: rtl/sramlike_data_responder.sv
// -----------------------------------------------------------------------------
// sramlike_data_responder
// Responder end of the sram-like data bus. It is the data memory for pipeline
// bring-up and stall testing. Requests are accepted through req/addr_ok. Each
// accepted request completes exactly LATENCY cycles later with a one-cycle
// data_ok pulse, and completions come back in order.
//   clk     : rising-edge clock
//   rst     : asynchronous reset, active low
//   req     : request valid
//   wr      : 1 = write, 0 = read
//   size    : 0 byte, 1 half, 2/3 word
//   addr    : byte address (bits above the RAM index are ignored)
//   wdata   : lane-aligned store data
//   addr_ok : request accepted this cycle when req is also high
//   rdata   : full aligned read word, zero for write completions
//   data_ok : completion pulse, one per accepted request
// -----------------------------------------------------------------------------
module sramlike_data_responder
    import sramlike_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter int          MAX_OUT     = 1,
    parameter bit          RAND_STALL  = 1'b0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic [31:0] rdata,
    output logic        data_ok
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic             run_reg;        // low until the first edge after reset release
    logic [15:0]      lfsr_reg;
    logic [CNT_W-1:0] cnt_reg;        // accepted but not yet completed
    logic             rd_valid_reg;   // stage 0 of the completion pipe
    logic             rd_is_wr_reg;
    logic             stall;
    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      rd_word;
    logic [31:0]      stage0_data;

    assign idx = addr[IDX_W+1:2];
    assign be  = byte_en(size, addr[1:0]);

    generate
        if (IDX_W + 2 <= 31) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[31:IDX_W+2];
        end
    endgenerate

    // Stress mode: the LFSR randomly withholds addr_ok.
    generate
        if (RAND_STALL) begin : g_stall
            assign stall = lfsr_reg[0] & lfsr_reg[3];
        end else begin : g_no_stall
            assign stall = 1'b0;
        end
    endgenerate

    // A completing request frees its slot in the same cycle. This lets a full
    // responder accept a new request on the cycle data_ok is high.
    assign addr_ok = run_reg && ((cnt_reg < CNT_W'(MAX_OUT)) || data_ok) && !stall;
    assign accept  = req & addr_ok;

    // Each byte lane is its own RAM with a registered read, so each lane maps
    // onto a block RAM. A write updates the array on the accept edge. A read
    // accepted on any later edge therefore already sees the new data. The
    // lanes are never cleared.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_reg;
            always_ff @(posedge clk) begin
                if (accept) begin
                    if (wr && be[gi]) begin
                        mem[idx] <= wdata[gi*8 +: 8];
                    end
                    rd_reg <= mem[idx];
                end
            end
            assign rd_word[gi*8 +: 8] = rd_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_reg      <= 1'b0;
            lfsr_reg     <= LFSR_SEED;
            cnt_reg      <= '0;
            rd_valid_reg <= 1'b0;
            rd_is_wr_reg <= 1'b0;
        end else begin
            run_reg      <= 1'b1;
            // Fibonacci LFSR, taps 16,14,13,11
            lfsr_reg     <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
            rd_valid_reg <= accept;
            if (accept) begin
                rd_is_wr_reg <= wr;
            end
            case ({accept, data_ok})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // The RAM's output register is stage 0. Zeroing the word for idle slots
    // and for write completions keeps rdata at zero outside of read data_ok.
    assign stage0_data = (rd_valid_reg && !rd_is_wr_reg) ? rd_word : 32'd0;

    generate
        if (LATENCY == 1) begin : g_lat1
            assign data_ok = rd_valid_reg;
            assign rdata   = stage0_data;
        end else begin : g_latn
            sramlike_delay_line #(
                .W       (32),
                .LATENCY (LATENCY - 1)
            ) u_delay (
                .clk        (clk),
                .rst        (rst),
                .load_valid (rd_valid_reg),
                .load_data  (stage0_data),
                .tap_valid  (data_ok),
                .tap_data   (rdata)
            );
        end
    endgenerate

endmodule

// File: tb/tb_sramlike_data_responder.sv
// -----------------------------------------------------------------------------
// tb_sramlike_data_responder
// Four responders with different LATENCY / MAX_OUT / RAND_STALL settings share
// one clock. A per-instance model of the bus rules checks every cycle. The
// model keeps a completion queue with due cycles, a byte-level memory image and
// the stall LFSR. Directed steps add targeted checks on top of that.
//   instance 0: LATENCY 2, MAX_OUT 1
//   instance 1: LATENCY 3, MAX_OUT 3
//   instance 2: LATENCY 1, MAX_OUT 1
//   instance 3: LATENCY 4, MAX_OUT 3, RAND_STALL
// -----------------------------------------------------------------------------
module tb_sramlike_data_responder;

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    localparam logic [3:0][3:0] LAT_P = {4'd4, 4'd1, 4'd3, 4'd2};
    localparam logic [3:0][3:0] MAX_P = {4'd3, 4'd1, 4'd3, 4'd1};
    localparam logic [3:0]      RS_P  = 4'b1000;
    localparam logic [15:0]     SEED  = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_s   [4];
    logic        req_s   [4];
    logic        wr_s    [4];
    logic [1:0]  size_s  [4];
    logic [31:0] addr_s  [4];
    logic [31:0] wdata_s [4];
    logic        aok_w   [4];
    logic [31:0] rd_w    [4];
    logic        dok_w   [4];

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          snap_cyc;
    logic        snap_aok [4];
    logic        snap_dok [4];
    logic [31:0] snap_rd  [4];

    exp_t        expq    [4][$];
    logic [31:0] mem_m   [4][256];
    logic [3:0]  known_m [4][256];
    logic [15:0] lfsr_m  [4];
    bit          run_m   [4];
    int          acc_cnt [4];
    int          dok_cnt [4];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        sramlike_data_responder #(
            .DEPTH_WORDS (1024),
            .LATENCY     (int'(LAT_P[gi])),
            .MAX_OUT     (int'(MAX_P[gi])),
            .RAND_STALL  (RS_P[gi]),
            .LFSR_SEED   (SEED)
        ) u_dut (
            .clk     (clk),
            .rst     (rst_s[gi]),
            .req     (req_s[gi]),
            .wr      (wr_s[gi]),
            .size    (size_s[gi]),
            .addr    (addr_s[gi]),
            .wdata   (wdata_s[gi]),
            .addr_ok (aok_w[gi]),
            .rdata   (rd_w[gi]),
            .data_ok (dok_w[gi])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, snap_cyc);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, snap_cyc);
        end
    endtask

    // The model applies an accepted request. A write updates the bytes it
    // covers and completes with zero. A read returns the current word and is
    // only checked once all four of its bytes have been written.
    task automatic model_accept(input int i);
        int   w;
        int   n;
        int   lo;
        exp_t e;
        w = int'(addr_s[i][9:2]);
        e.due = snap_cyc + int'(LAT_P[i]);
        acc_cnt[i]++;
        if (wr_s[i]) begin
            n  = (size_s[i] == 2'd0) ? 1 : (size_s[i] == 2'd1) ? 2 : 4;
            lo = (n == 4) ? 0 : (n == 2) ? (addr_s[i][1] ? 2 : 0) : int'(addr_s[i][1:0]);
            for (int k = lo; k < lo + n; k++) begin
                mem_m[i][w][8*k +: 8] = wdata_s[i][8*k +: 8];
                known_m[i][w][k]      = 1'b1;
            end
            e.data = 32'd0;
            e.chk  = 1'b1;
        end else begin
            e.data = mem_m[i][w];
            e.chk  = &known_m[i][w];
        end
        expq[i].push_back(e);
    endtask

    task automatic check_inst(input int i);
        bit   exp_ok;
        bit   exp_aok;
        bit   stall;
        exp_t e;
        if (snap_dok[i] === 1'b1) dok_cnt[i]++;
        if (rst_s[i] === 1'b0) begin
            chk_bit($sformatf("rst_addr_ok[%0d]", i), snap_aok[i], 1'b0);
            chk_bit($sformatf("rst_data_ok[%0d]", i), snap_dok[i], 1'b0);
            chk($sformatf("rst_rdata[%0d]", i), snap_rd[i], 32'd0);
            expq[i].delete();
            lfsr_m[i] = SEED;
            run_m[i]  = 1'b0;
        end else begin
            exp_ok = 1'b0;
            if (expq[i].size() > 0) exp_ok = (expq[i][0].due == snap_cyc);
            stall   = RS_P[i] && lfsr_m[i][0] && lfsr_m[i][3];
            exp_aok = run_m[i] && ((expq[i].size() < int'(MAX_P[i])) || exp_ok) && !stall;
            chk_bit($sformatf("addr_ok[%0d]", i), snap_aok[i], exp_aok);
            chk_bit($sformatf("data_ok[%0d]", i), snap_dok[i], exp_ok);
            if (exp_ok) begin
                e = expq[i].pop_front();
                if (e.chk) chk($sformatf("rdata[%0d]", i), snap_rd[i], e.data);
            end
            if (req_s[i] && exp_aok) model_accept(i);
            lfsr_m[i] = {lfsr_m[i][14:0], lfsr_m[i][15] ^ lfsr_m[i][13] ^ lfsr_m[i][12] ^ lfsr_m[i][10]};
            run_m[i]  = 1'b1;
        end
    endtask

    // One bus cycle. Outputs are sampled and checked on the falling edge.
    // The task returns just after the next rising edge, which is where the
    // caller drives new inputs.
    task automatic step();
        @(negedge clk);
        snap_cyc = cyc;
        for (int i = 0; i < 4; i++) begin
            snap_aok[i] = aok_w[i];
            snap_dok[i] = dok_w[i];
            snap_rd[i]  = rd_w[i];
            check_inst(i);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int i, input bit w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output int acc_c);
        req_s[i]   = 1'b1;
        wr_s[i]    = w;
        size_s[i]  = sz;
        addr_s[i]  = a;
        wdata_s[i] = d;
        acc_c = -1;
        for (int k = 0; k < 64 && acc_c < 0; k++) begin
            step();
            if (snap_aok[i] === 1'b1) acc_c = snap_cyc;
        end
        req_s[i] = 1'b0;
        n_tests++;
        assert (acc_c >= 0) else begin
            n_fail++;
            $error("FAIL xfer_timeout[%0d] observed=no addr_ok in 64 cycles expected=accept", i);
        end
    endtask

    task automatic wait_dok(input int i, output int c, output logic [31:0] d);
        c = -1;
        d = 32'd0;
        for (int k = 0; k < 64 && c < 0; k++) begin
            step();
            if (snap_dok[i] === 1'b1) begin
                c = snap_cyc;
                d = snap_rd[i];
            end
        end
        n_tests++;
        assert (c >= 0) else begin
            n_fail++;
            $error("FAIL dok_timeout[%0d] observed=no data_ok in 64 cycles expected=data_ok", i);
        end
    endtask

    initial begin
        int          wc, rc, c, c0, c1, c2, c3, n_acc6;
        logic [31:0] d;
        bit          w;
        logic [1:0]  sz;
        logic [31:0] a;

        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        n_acc6  = 0;
        for (int i = 0; i < 4; i++) begin
            rst_s[i]   = 1'b0;
            req_s[i]   = 1'b0;
            wr_s[i]    = 1'b0;
            size_s[i]  = 2'd0;
            addr_s[i]  = 32'd0;
            wdata_s[i] = 32'd0;
            lfsr_m[i]  = SEED;
            run_m[i]   = 1'b0;
            acc_cnt[i] = 0;
            dok_cnt[i] = 0;
            for (int k = 0; k < 256; k++) begin
                mem_m[i][k]   = 32'd0;
                known_m[i][k] = 4'd0;
            end
        end

        // reset state, then release
        step();
        step();
        for (int i = 0; i < 4; i++) rst_s[i] = 1'b1;
        step();
        step();

        // write then read, LATENCY 2 / MAX_OUT 1
        xfer(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, wc);
        xfer(0, 1'b0, 2'd2, 32'h10, 32'd0, rc);
        chk("l2_read_accept_delay", 32'(rc - wc), 32'd2);
        wait_dok(0, c, d);
        chk("l2_read_latency", 32'(c - rc), 32'd2);
        chk("l2_read_data", d, 32'hDEADBEEF);

        // byte and half merges into an existing word
        xfer(0, 1'b1, 2'd2, 32'h20, 32'h11223344, c);
        xfer(0, 1'b1, 2'd0, 32'h22, 32'h00AA0000, c);
        xfer(0, 1'b0, 2'd2, 32'h20, 32'd0, c);
        wait_dok(0, c, d);
        chk("byte_merge", d, 32'h11AA3344);
        xfer(0, 1'b1, 2'd1, 32'h21, 32'h0000BEEF, c);
        xfer(0, 1'b0, 2'd2, 32'h20, 32'd0, c);
        wait_dok(0, c, d);
        chk("half_merge", d, 32'h11AABEEF);

        // LATENCY 3 / MAX_OUT 3: pipelined reads in order, fourth waits for first data_ok
        xfer(1, 1'b1, 2'd2, 32'h40, 32'hA0A0A0A0, c);
        xfer(1, 1'b1, 2'd2, 32'h44, 32'hB1B1B1B1, c);
        xfer(1, 1'b1, 2'd2, 32'h48, 32'hC2C2C2C2, c);
        for (int k = 0; k < 4; k++) step();
        xfer(1, 1'b0, 2'd2, 32'h40, 32'd0, c0);
        xfer(1, 1'b0, 2'd2, 32'h44, 32'd0, c1);
        xfer(1, 1'b0, 2'd2, 32'h48, 32'd0, c2);
        xfer(1, 1'b0, 2'd2, 32'h40, 32'd0, c3);
        chk("l3_b2b_1", 32'(c1 - c0), 32'd1);
        chk("l3_b2b_2", 32'(c2 - c0), 32'd2);
        chk("l3_fourth_on_first_dok", 32'(c3 - c0), 32'd3);
        wait_dok(1, c, d);
        chk("l3_second_cycle", 32'(c - c0), 32'd4);
        chk("l3_second_data", d, 32'hB1B1B1B1);
        wait_dok(1, c, d);
        chk("l3_third_data", d, 32'hC2C2C2C2);
        wait_dok(1, c, d);
        chk("l3_fourth_cycle", 32'(c - c3), 32'd3);
        chk("l3_fourth_data", d, 32'hA0A0A0A0);

        // LATENCY 1 / MAX_OUT 1: continuous requests, every accept rides a data_ok
        xfer(2, 1'b1, 2'd2, 32'h0, 32'h12345678, c);
        req_s[2]  = 1'b1;
        wr_s[2]   = 1'b0;
        size_s[2] = 2'd2;
        addr_s[2] = 32'h0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_bit("l1_accept", snap_aok[2], 1'b1);
            chk_bit("l1_coincident_dok", snap_dok[2], 1'b1);
            chk("l1_rdata", snap_rd[2], (k == 0) ? 32'd0 : 32'h12345678);
        end
        req_s[2] = 1'b0;
        step();
        step();

        // reset with two reads pending on instance 1
        xfer(1, 1'b1, 2'd2, 32'h80, 32'hCAFEF00D, c);
        for (int k = 0; k < 4; k++) step();
        xfer(1, 1'b0, 2'd2, 32'h40, 32'd0, c);
        xfer(1, 1'b0, 2'd2, 32'h44, 32'd0, c);
        rst_s[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_bit("mid_rst_addr_ok", snap_aok[1], 1'b0);
            chk_bit("mid_rst_data_ok", snap_dok[1], 1'b0);
        end
        rst_s[1] = 1'b1;
        step();
        chk_bit("post_rst_first_cycle_addr_ok", snap_aok[1], 1'b0);
        step();
        chk_bit("post_rst_cnt_zero_addr_ok", snap_aok[1], 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_bit("post_rst_no_dok", snap_dok[1], 1'b0);
        end
        xfer(1, 1'b0, 2'd2, 32'h80, 32'd0, c);
        wait_dok(1, c, d);
        chk("ram_survives_reset", d, 32'hCAFEF00D);

        // random stress with stalls, LATENCY 4 / MAX_OUT 3
        for (int k = 0; k < 1000; k++) begin
            if (k < 64) begin
                w  = 1'b1;
                sz = 2'd2;
                a  = 32'(k * 4);
            end else begin
                w  = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                a  = 32'($urandom_range(0, 255));
            end
            d = $urandom;
            if ($urandom_range(0, 4) == 0) step();
            xfer(3, w, sz, a, d, c);
            if (c >= 0) n_acc6++;
        end
        for (int k = 0; k < 10; k++) step();
        chk("rs_accept_count", 32'(n_acc6), 32'd1000);
        chk("rs_model_accepts", 32'(acc_cnt[3]), 32'(n_acc6));
        chk("rs_one_dok_per_accept", 32'(dok_cnt[3]), 32'(n_acc6));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
